sna_request_receiver: RTL and testbench

SNA_REQUEST_RECEIVER -- requirements
Module: sna_request_receiver

---
 rtl/sna_request_receiver_pkg.sv | 59 +++++
 rtl/sna_flit_decoder.sv | 33 +++
 rtl/sna_request_receiver.sv | 157 +++++++++++++++
 tb/tb_sna_request_receiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sna_request_receiver_pkg.sv
// Shared definitions for the SNA request receiver and response transmitter:
// flit layout, type codes, VC count and the receiver FSM state encoding.
package sna_request_receiver_pkg;

  localparam int FLIT_W    = 37;
  localparam int PAYLOAD_W = 32;
  localparam int VC_NUM    = 8;
  localparam int VC_W      = 3;

  localparam int TYPE_HI  = 36;
  localparam int TYPE_LO  = 35;
  localparam int VC_HI    = 34;
  localparam int VC_LO    = 32;
  localparam int DEST_HI  = 31;
  localparam int DEST_LO  = 28;
  localparam int SRC_HI   = 27;
  localparam int SRC_LO   = 24;
  localparam int CMD_BIT  = 23;
  localparam int WSTRB_HI = 19;
  localparam int WSTRB_LO = 16;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = 2'b01,
    FLIT_HEAD = 2'b10
  } flit_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_AXI_WRITE = 3'd3,
    ST_AXI_READ  = 3'd4
  } state_e;

  // One-hot flag vector selecting a single virtual channel
  function automatic logic [VC_NUM-1:0] vc_onehot(input logic [VC_W-1:0] vc);
    logic [VC_NUM-1:0] mask;
    mask     = '0;
    mask[vc] = 1'b1;
    return mask;
  endfunction

  // Response head: src and dest swap places relative to the request
  function automatic logic [FLIT_W-1:0] make_resp_header(
    input logic [VC_W-1:0] vc,
    input logic [3:0]      req_src,
    input logic [3:0]      req_dest,
    input logic            req_cmd
  );
    return {FLIT_HEAD, vc, req_src, req_dest, req_cmd, 23'd0};
  endfunction

  // Response tail carries no payload
  function automatic logic [FLIT_W-1:0] make_resp_tail(input logic [VC_W-1:0] vc);
    return {FLIT_TAIL, vc, 32'd0};
  endfunction

endpackage

// File: rtl/sna_flit_decoder.sv
// Purely combinational field extraction and type classification of a NoC flit.
module sna_flit_decoder
  import sna_request_receiver_pkg::*;
(
  input  logic [FLIT_W-1:0]    flit,
  output logic                 is_head,
  output logic                 is_body,
  output logic                 is_tail,
  output logic [VC_W-1:0]      vc,
  output logic [3:0]           dest,
  output logic [3:0]           src,
  output logic                 cmd,
  output logic [3:0]           strb,
  output logic [PAYLOAD_W-1:0] payload
);

  logic [1:0] flit_type;

  // Slice the flit into its named fields; type 2'b11 classifies as nothing
  always_comb begin
    flit_type = flit[TYPE_HI:TYPE_LO];
    is_head   = (flit_type == FLIT_HEAD);
    is_body   = (flit_type == FLIT_BODY);
    is_tail   = (flit_type == FLIT_TAIL);
    vc        = flit[VC_HI:VC_LO];
    dest      = flit[DEST_HI:DEST_LO];
    src       = flit[SRC_HI:SRC_LO];
    cmd       = flit[CMD_BIT];
    strb      = flit[WSTRB_HI:WSTRB_LO];
    payload   = flit[PAYLOAD_W-1:0];
  end

endmodule

// File: rtl/sna_request_receiver.sv
// Receives request packets from the NoC, assembles address/data and issues
// a single AXI4-Lite write or read per packet. All outputs are registered.
module sna_request_receiver
  import sna_request_receiver_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [FLIT_W-1:0]    noc_data,
  input  logic                 is_valid,
  output logic [VC_NUM-1:0]    is_allocatable,
  output logic [VC_NUM-1:0]    is_on_off,
  output logic [31:0]          awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [31:0]          araddr,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [FLIT_W-1:0]    resp_header,
  output logic [FLIT_W-1:0]    resp_tail
);

  logic                 dec_is_head;
  logic                 dec_is_body;
  logic                 dec_is_tail;
  logic [VC_W-1:0]      dec_vc;
  logic [3:0]           dec_dest;
  logic [3:0]           dec_src;
  logic                 dec_cmd;
  logic [3:0]           dec_strb;
  logic [PAYLOAD_W-1:0] dec_payload;

  state_e          state;
  logic [VC_W-1:0] cur_vc;
  logic            cur_cmd;
  logic            run_q;

  logic accept;
  logic start_head;
  logic on_vc;
  logic aw_done;
  logic w_done;

  sna_flit_decoder u_decoder (
    .flit    (noc_data),
    .is_head (dec_is_head),
    .is_body (dec_is_body),
    .is_tail (dec_is_tail),
    .vc      (dec_vc),
    .dest    (dec_dest),
    .src     (dec_src),
    .cmd     (dec_cmd),
    .strb    (dec_strb),
    .payload (dec_payload)
  );

  // Gate flit acceptance for the first edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Acceptance qualifiers and AXI channel completion (done = already handshaken or handshaking now)
  always_comb begin
    accept     = is_valid && run_q;
    start_head = accept && dec_is_head &&
                 (state == ST_IDLE || state == ST_GET_ADDR || state == ST_GET_DATA);
    on_vc      = (dec_vc == cur_vc);
    aw_done    = !awvalid || awready;
    w_done     = !wvalid || wready;
  end

  // Packet assembly FSM with registered AXI and flow-control outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cur_vc         <= '0;
      cur_cmd        <= 1'b0;
      awaddr         <= '0;
      awvalid        <= 1'b0;
      wdata          <= '0;
      wstrb          <= '0;
      wvalid         <= 1'b0;
      araddr         <= '0;
      arvalid        <= 1'b0;
      resp_header    <= '0;
      resp_tail      <= '0;
      is_allocatable <= '1;
      is_on_off      <= '1;
    end else if (start_head) begin
      state          <= ST_GET_ADDR;
      cur_vc         <= dec_vc;
      cur_cmd        <= dec_cmd;
      wstrb          <= dec_strb;
      resp_header    <= make_resp_header(dec_vc, dec_src, dec_dest, dec_cmd);
      resp_tail      <= make_resp_tail(dec_vc);
      is_allocatable <= '0;
      is_on_off      <= vc_onehot(dec_vc);
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_GET_ADDR: begin
          if (accept && on_vc) begin
            if (cur_cmd && dec_is_body) begin
              awaddr <= dec_payload;
              state  <= ST_GET_DATA;
            end else if (!cur_cmd && dec_is_tail) begin
              araddr    <= dec_payload;
              arvalid   <= 1'b1;
              is_on_off <= '0;
              state     <= ST_AXI_READ;
            end
          end
        end
        ST_GET_DATA: begin
          if (accept && on_vc && dec_is_tail) begin
            wdata     <= dec_payload;
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            is_on_off <= '0;
            state     <= ST_AXI_WRITE;
          end
        end
        ST_AXI_WRITE: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state          <= ST_IDLE;
            is_allocatable <= '1;
            is_on_off      <= '1;
          end
        end
        ST_AXI_READ: begin
          if (arready) begin
            arvalid        <= 1'b0;
            state          <= ST_IDLE;
            is_allocatable <= '1;
            is_on_off      <= '1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          awvalid        <= 1'b0;
          wvalid         <= 1'b0;
          arvalid        <= 1'b0;
          is_allocatable <= '1;
          is_on_off      <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sna_request_receiver.sv
// Scoreboard bench for sna_request_receiver: stimulus pushes expected AXI
// transactions, a negedge monitor pops and compares on every handshake.
module tb_sna_request_receiver;

  logic        clock;
  logic        reset_n;
  logic [36:0] noc_data;
  logic        is_valid;
  logic [7:0]  is_allocatable;
  logic [7:0]  is_on_off;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [36:0] resp_header;
  logic [36:0] resp_tail;

  int checks = 0;
  int errors = 0;
  int ar_cycles = 0;

  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ar[$];

  sna_request_receiver dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .noc_data       (noc_data),
    .is_valid       (is_valid),
    .is_allocatable (is_allocatable),
    .is_on_off      (is_on_off),
    .awaddr         (awaddr),
    .awvalid        (awvalid),
    .awready        (awready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wvalid         (wvalid),
    .wready         (wready),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .resp_header    (resp_header),
    .resp_tail      (resp_tail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one flit for exactly one rising edge, return 1ns after that edge
  task automatic applyStimulus(input logic [36:0] flit);
    @(negedge clock);
    noc_data = flit;
    is_valid = 1'b1;
    @(posedge clock);
    #1;
    is_valid = 1'b0;
  endtask

  function automatic logic [36:0] mk_head(input logic [2:0] vc, input logic [3:0] dest,
                                          input logic [3:0] src, input logic cmd, input logic [3:0] strb);
    return {2'b10, vc, dest, src, cmd, 3'b000, strb, 16'h0000};
  endfunction

  function automatic logic [36:0] mk_flit(input logic [1:0] ftype, input logic [2:0] vc, input logic [31:0] payload);
    return {ftype, vc, payload};
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Bounded wait for the receiver to report IDLE again
  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (is_allocatable == 8'hFF) break;
      @(posedge clock);
      #1;
    end
    checkOutput(name, {56'd0, is_allocatable}, 64'hFF);
  endtask

  // Monitor: compare handshakes against the scoreboard and check valid/payload stability
  logic        aw_pend, w_pend, ar_pend;
  logic [31:0] aw_hold, ar_hold;
  logic [35:0] w_hold;
  logic [35:0] w_got;
  logic [35:0] w_exp;
  initial begin
    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    aw_hold = '0; ar_hold = '0; w_hold = '0;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    end else begin
      if (arvalid) ar_cycles++;
      w_got = {wdata, wstrb};
      if (aw_pend) begin
        checkOutput("awvalid_held", {63'd0, awvalid}, 64'd1);
        checkOutput("awaddr_stable", {32'd0, awaddr}, {32'd0, aw_hold});
      end
      if (w_pend) begin
        checkOutput("wvalid_held", {63'd0, wvalid}, 64'd1);
        checkOutput("wdata_stable", {28'd0, w_got}, {28'd0, w_hold});
      end
      if (ar_pend) begin
        checkOutput("arvalid_held", {63'd0, arvalid}, 64'd1);
        checkOutput("araddr_stable", {32'd0, araddr}, {32'd0, ar_hold});
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL aw_unexpected: got awaddr %h expected no handshake", awaddr);
        end else checkOutput("aw_addr", {32'd0, awaddr}, {32'd0, exp_aw.pop_front()});
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL w_unexpected: got wdata %h expected no handshake", wdata);
        end else begin
          w_exp = exp_w.pop_front();
          checkOutput("w_data_strb", {28'd0, w_got}, {28'd0, w_exp});
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL ar_unexpected: got araddr %h expected no handshake", araddr);
        end else checkOutput("ar_addr", {32'd0, araddr}, {32'd0, exp_ar.pop_front()});
      end
      aw_pend = awvalid && !awready; aw_hold = awaddr;
      w_pend  = wvalid && !wready;   w_hold  = w_got;
      ar_pend = arvalid && !arready; ar_hold = araddr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    noc_data = '0;
    is_valid = 1'b0;
    awready  = 1'b1;
    wready   = 1'b1;
    arready  = 1'b1;

    // Reset values
    wait_cycles(2);
    checkOutput("rst_alloc",   {56'd0, is_allocatable}, 64'hFF);
    checkOutput("rst_on_off",  {56'd0, is_on_off}, 64'hFF);
    checkOutput("rst_valids",  {61'd0, awvalid, wvalid, arvalid}, 64'd0);
    checkOutput("rst_resp_hd", {27'd0, resp_header}, 64'd0);

    // Flit on the first edge after release must be ignored
    @(posedge clock); #3; reset_n = 1'b1;
    applyStimulus(37'h11_318F_0000);
    checkOutput("first_edge_drop_alloc", {56'd0, is_allocatable}, 64'hFF);
    checkOutput("first_edge_drop_onoff", {56'd0, is_on_off}, 64'hFF);
    wait_cycles(2);

    // Basic write on VC1
    applyStimulus(37'h11_318F_0000);
    checkOutput("wr_alloc",    {56'd0, is_allocatable}, 64'h00);
    checkOutput("wr_on_off",   {56'd0, is_on_off}, 64'h02);
    checkOutput("wr_resp_hd",  {27'd0, resp_header}, {27'd0, 37'h11_1380_0000});
    checkOutput("wr_resp_tl",  {27'd0, resp_tail}, {27'd0, 37'h09_0000_0000});
    applyStimulus(37'h01_0000_0040);
    exp_aw.push_back(32'h40);
    exp_w.push_back({32'hDEAD_BEEF, 4'hF});
    applyStimulus(37'h09_DEAD_BEEF);
    checkOutput("wr_latency",  {62'd0, awvalid, wvalid}, 64'd3);
    checkOutput("wr_on_off_axi", {56'd0, is_on_off}, 64'h00);
    wait_idle("wr_idle", 10);
    checkOutput("wr_valids_low", {62'd0, awvalid, wvalid}, 64'd0);

    // Read on VC2 with arready delayed 3 cycles
    arready = 1'b0;
    applyStimulus(mk_head(3'd2, 4'd5, 4'd6, 1'b0, 4'h0));
    checkOutput("rd_on_off_hd", {56'd0, is_on_off}, 64'h04);
    exp_ar.push_back(32'h80);
    ar_cycles = 0;
    applyStimulus(mk_flit(2'b01, 3'd2, 32'h80));
    for (int i = 0; i < 3; i++) begin
      checkOutput("rd_arvalid_wait", {63'd0, arvalid}, 64'd1);
      checkOutput("rd_araddr", {32'd0, araddr}, 64'h80);
      checkOutput("rd_on_off", {56'd0, is_on_off}, 64'h00);
      wait_cycles(1);
    end
    arready = 1'b1;
    checkOutput("rd_arvalid_last", {63'd0, arvalid}, 64'd1);
    wait_cycles(1);
    checkOutput("rd_arvalid_drop", {63'd0, arvalid}, 64'd0);
    checkOutput("rd_idle", {56'd0, is_allocatable}, 64'hFF);
    checkOutput("rd_ar_cycles", 64'(ar_cycles), 64'd4);

    // Write with awready delayed 2 cycles, wready high
    awready = 1'b0;
    applyStimulus(mk_head(3'd3, 4'd2, 4'd4, 1'b1, 4'h3));
    applyStimulus(mk_flit(2'b00, 3'd3, 32'h100));
    exp_aw.push_back(32'h100);
    exp_w.push_back({32'h1234_5678, 4'h3});
    applyStimulus(mk_flit(2'b01, 3'd3, 32'h1234_5678));
    checkOutput("aw_dly_both", {62'd0, awvalid, wvalid}, 64'd3);
    wait_cycles(1);
    checkOutput("aw_dly_w_drop", {62'd0, awvalid, wvalid}, 64'd2);
    checkOutput("aw_dly_busy", {56'd0, is_allocatable}, 64'h00);
    wait_cycles(1);
    checkOutput("aw_dly_hold", {62'd0, awvalid, wvalid}, 64'd2);
    awready = 1'b1;
    wait_cycles(1);
    checkOutput("aw_dly_done", {62'd0, awvalid, wvalid}, 64'd0);
    checkOutput("aw_dly_idle", {56'd0, is_allocatable}, 64'hFF);

    // Stray tail in IDLE and a wrong-VC body while waiting for the address
    applyStimulus(mk_flit(2'b01, 3'd0, 32'hBAD0_0001));
    checkOutput("drop_tail_idle", {56'd0, is_allocatable}, 64'hFF);
    applyStimulus(mk_head(3'd1, 4'd3, 4'd1, 1'b1, 4'hC));
    applyStimulus(mk_flit(2'b00, 3'd5, 32'hBAD0_0002));
    applyStimulus(mk_flit(2'b01, 3'd1, 32'hBAD0_0003));
    wait_cycles(2);
    checkOutput("drop_on_off", {56'd0, is_on_off}, 64'h02);
    checkOutput("drop_no_axi", {62'd0, awvalid, wvalid}, 64'd0);
    applyStimulus(mk_flit(2'b00, 3'd1, 32'h200));
    exp_aw.push_back(32'h200);
    exp_w.push_back({32'hCAFE_F00D, 4'hC});
    applyStimulus(mk_flit(2'b01, 3'd1, 32'hCAFE_F00D));
    wait_idle("drop_idle", 10);

    // Second head before the body replaces the first header
    applyStimulus(mk_head(3'd1, 4'd3, 4'd1, 1'b1, 4'hF));
    applyStimulus(mk_head(3'd4, 4'd7, 4'd2, 1'b0, 4'h0));
    checkOutput("rehead_on_off", {56'd0, is_on_off}, 64'h10);
    checkOutput("rehead_resp_hd", {27'd0, resp_header}, {27'd0, 37'h14_2700_0000});
    checkOutput("rehead_resp_tl", {27'd0, resp_tail}, {27'd0, 37'h0C_0000_0000});
    exp_ar.push_back(32'h300);
    applyStimulus(mk_flit(2'b01, 3'd4, 32'h300));
    wait_idle("rehead_idle", 10);

    // Reset during an AW transfer abandons it
    awready = 1'b0;
    wready  = 1'b0;
    applyStimulus(mk_head(3'd6, 4'd1, 4'd2, 1'b1, 4'h5));
    applyStimulus(mk_flit(2'b00, 3'd6, 32'h400));
    applyStimulus(mk_flit(2'b01, 3'd6, 32'h55AA_55AA));
    checkOutput("rst_axi_pre", {62'd0, awvalid, wvalid}, 64'd3);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_axi_valids", {62'd0, awvalid, wvalid}, 64'd0);
    checkOutput("rst_axi_addr",   {32'd0, awaddr}, 64'd0);
    checkOutput("rst_axi_data",   {28'd0, wdata, wstrb}, 64'd0);
    checkOutput("rst_axi_resp",   {27'd0, resp_header}, 64'd0);
    checkOutput("rst_axi_alloc",  {48'd0, is_allocatable, is_on_off}, 64'hFFFF);
    awready = 1'b1;
    wready  = 1'b1;
    @(posedge clock); #3; reset_n = 1'b1;
    wait_cycles(3);
    checkOutput("rst_no_replay", {62'd0, awvalid, wvalid}, 64'd0);
    applyStimulus(mk_head(3'd0, 4'd1, 4'd2, 1'b1, 4'h1));
    applyStimulus(mk_flit(2'b00, 3'd0, 32'h10));
    exp_aw.push_back(32'h10);
    exp_w.push_back({32'h0000_0001, 4'h1});
    applyStimulus(mk_flit(2'b01, 3'd0, 32'h1));
    wait_idle("post_rst_idle", 10);

    wait_cycles(3);
    checkOutput("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    checkOutput("w_queue_empty",  64'(exp_w.size()), 64'd0);
    checkOutput("ar_queue_empty", 64'(exp_ar.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
